// File: rtl/pec_ram_sched_if.sv
// Requester-side bus of the PEC RAM scheduler: one writer, NUM_RD readers and
// the tagged read-response channel.
interface pec_ram_sched_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 28,
   parameter int unsigned NUM_RD = 4,
   parameter int unsigned ID_W   = 2
);
   logic                     wr_req;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     wr_gnt;
   logic [NUM_RD-1:0]        rd_req;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0]        rd_gnt;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [DATA_W-1:0]        rsp_data;
   logic                     rsp_err;
   logic                     wr_err;

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr,
      input  wr_gnt, rd_gnt, rsp_valid, rsp_id, rsp_data, rsp_err, wr_err
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
      output wr_gnt, rd_gnt, rsp_valid, rsp_id, rsp_data, rsp_err, wr_err
   );
endinterface

// File: rtl/pec_ram_sched.sv
// Single-port PEC RAM access scheduler: write priority with a burst limiter,
// round-robin readers, 1-cycle tagged read responses and range checking.
module pec_ram_sched #(
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned DATA_W       = 28,
   parameter int unsigned NUM_RD       = 4,
   parameter int unsigned ID_W         = 2,
   parameter int unsigned DEPTH_MAX    = 196,
   parameter int unsigned WR_BURST_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   pec_ram_sched_if.slave    bus,
   output logic [ADDR_W-1:0] ram_addr_r,
   output logic [ADDR_W-1:0] ram_addr_w,
   output logic              ram_read_en,
   output logic              ram_write_en,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam int unsigned     STREAK_W    = (WR_BURST_MAX < 4) ? 2 : $clog2(WR_BURST_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(WR_BURST_MAX - 1);
   localparam logic [ID_W:0]   NUM_RD_L    = (ID_W + 1)'(NUM_RD);
   localparam logic [ID_W-1:0] LAST_RD     = ID_W'(NUM_RD - 1);

   typedef enum logic [0:0] {WR_PRI, RD_PRI} state_t;

   state_t              state, state_n;
   logic [STREAK_W-1:0] streak, streak_n;
   logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
   logic [ID_W-1:0]     rr_idx;
   logic                rr_hit;
   logic                any_rd;
   logic                wr_win, rd_win;
   logic                wr_in_range, rd_in_range;
   logic [ADDR_W-1:0]   sel_addr;

   logic                rsp_valid_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic                rsp_err_q;
   logic                wr_err_q;

   assign any_rd = |bus.rd_req;

   // Round-robin search: first pending reader at or after rr_ptr, wrapping.
   always_comb begin : rr_search
      logic [ID_W:0] cand;
      rr_hit = 1'b0;
      rr_idx = '0;
      cand   = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         cand = {1'b0, rr_ptr} + (ID_W + 1)'(i);
         if (cand >= NUM_RD_L) begin
            cand = cand - NUM_RD_L;
         end
         if (!rr_hit && bus.rd_req[cand[ID_W-1:0]]) begin
            rr_hit = 1'b1;
            rr_idx = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (rr_idx == ID_W'(i)) begin
            sel_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign wr_in_range = (32'(bus.wr_addr) < DEPTH_MAX);
   assign rd_in_range = (32'(sel_addr) < DEPTH_MAX);

   // RD_PRI only blocks the writer when a reader is actually waiting.
   assign wr_win = !rst && bus.wr_req && ((state == WR_PRI) || !any_rd);
   assign rd_win = !rst && rr_hit && !wr_win;

   always_comb begin
      bus.rd_gnt = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         bus.rd_gnt[i] = rd_win && (rr_idx == ID_W'(i));
      end
   end

   assign bus.wr_gnt   = wr_win;
   assign ram_write_en = wr_win && wr_in_range;
   assign ram_addr_w   = wr_win ? bus.wr_addr : '0;
   assign ram_data_in  = wr_win ? bus.wr_data : '0;
   assign ram_read_en  = rd_win && rd_in_range;
   assign ram_addr_r   = rd_win ? sel_addr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= WR_PRI;
         streak <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         streak <= streak_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      state_n  = WR_PRI;
      streak_n = '0;
      rr_ptr_n = rr_ptr;
      case (state)
         WR_PRI: begin
            if (wr_win && any_rd) begin
               if (streak == STREAK_LAST) begin
                  state_n = RD_PRI;
               end else begin
                  streak_n = streak + 1'b1;
               end
            end
         end
         RD_PRI: state_n = WR_PRI;
         default: state_n = WR_PRI;
      endcase
      if (rd_win) begin
         rr_ptr_n = (rr_idx == LAST_RD) ? '0 : rr_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         rsp_valid_q <= rd_win;
         rsp_err_q   <= rd_win && !rd_in_range;
         if (rd_win) begin
            rsp_id_q <= rr_idx;
         end
         if (wr_win && !wr_in_range) begin
            wr_err_q <= 1'b1;
         end
      end
   end

   // Gating with rst suppresses a response whose grant preceded the reset cycle.
   assign bus.rsp_valid = rsp_valid_q && !rst;
   assign bus.rsp_id    = rst ? '0 : rsp_id_q;
   assign bus.rsp_err   = rsp_err_q && !rst;
   assign bus.wr_err    = wr_err_q && !rst;
   assign bus.rsp_data  = (bus.rsp_valid && !rsp_err_q) ? ram_data_out : '0;

endmodule

// File: tb/tb_pec_ram_sched.sv
// Directed self-checking bench for pec_ram_sched with a behavioural RAM model.
module tb_pec_ram_sched;
   // Address width widened and depth reduced so both addr 200 and addr 63 are out of range.
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 28;
   localparam int unsigned NR    = 4;
   localparam int unsigned IW    = 2;
   localparam int unsigned DEPTH = 60;

   logic          clk;
   logic          rst;
   logic [AW-1:0] ram_addr_r, ram_addr_w;
   logic          ram_read_en, ram_write_en;
   logic [DW-1:0] ram_data_in, ram_data_out;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_errors = 0;

   pec_ram_sched_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .ID_W(IW)) bus ();

   pec_ram_sched #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .ID_W(IW),
      .DEPTH_MAX(DEPTH), .WR_BURST_MAX(3)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .ram_addr_r(ram_addr_r), .ram_addr_w(ram_addr_w),
      .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
      if (ram_read_en)  ram_data_out    <= mem[ram_addr_r];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) check("rw_excl", 32'(ram_read_en & ram_write_en), 32'd0);

   function automatic logic [DW-1:0] d_of(input int unsigned i);
      return 28'h0A5A000 + DW'(i);
   endfunction

   task automatic set_rd_addr(input int unsigned i, input logic [AW-1:0] a);
      bus.rd_addr[i*AW +: AW] = a;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 8'd5;
      bus.wr_data = 28'h1111111;
      bus.rd_req  = 4'b1111;
      bus.rd_addr = '0;
      ram_data_out = '0;

      // Reset held 3 cycles with every request high.
      for (int c = 0; c < 3; c++) begin
         #2;
         check("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
         check("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
         check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check("rst_ram_en", 32'({ram_read_en, ram_write_en}), 32'd0);
         check("rst_ram_addr_w", 32'(ram_addr_w), 32'd0);
         check("rst_ram_data_in", 32'(ram_data_in), 32'd0);
         next_cycle();
      end
      rst        = 1'b0;
      bus.wr_req = 1'b0;
      bus.rd_req = '0;
      #2;
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("post_rst_wr_err", 32'(bus.wr_err), 32'd0);
      next_cycle();

      // Preload addresses 10..13 for the round-robin reads.
      for (int i = 0; i < 4; i++) begin
         bus.wr_req  = 1'b1;
         bus.wr_addr = AW'(10 + i);
         bus.wr_data = d_of(i);
         #2;
         check("pre_wr_gnt", 32'(bus.wr_gnt), 32'd1);
         check("pre_ram_addr_w", 32'(ram_addr_w), 32'(10 + i));
         next_cycle();
      end
      bus.wr_req = 1'b0;

      // Round-robin from rr_ptr=0 with all readers requesting.
      bus.rd_req = 4'b1111;
      for (int i = 0; i < 4; i++) set_rd_addr(i, AW'(10 + i));
      for (int c = 0; c < 5; c++) begin
         #2;
         check("rr_rd_gnt", 32'(bus.rd_gnt), 32'(1 << (c % 4)));
         check("rr_ram_addr_r", 32'(ram_addr_r), 32'(10 + c % 4));
         check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(c > 0));
         if (c > 0) begin
            check("rr_rsp_id", 32'(bus.rsp_id), 32'((c - 1) % 4));
            check("rr_rsp_data", 32'(bus.rsp_data), 32'(d_of((c - 1) % 4)));
         end
         next_cycle();
      end
      bus.rd_req = '0;
      #2;
      check("rr_last_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("rr_last_rsp_data", 32'(bus.rsp_data), 32'(d_of(0)));
      next_cycle();

      // Single write then read from reader 2 in the following cycle.
      bus.wr_req  = 1'b1;
      bus.wr_addr = 8'd5;
      bus.wr_data = 28'h0ABCDEF;
      #2;
      check("sw_wr_gnt", 32'(bus.wr_gnt), 32'd1);
      check("sw_ram_write_en", 32'(ram_write_en), 32'd1);
      check("sw_ram_data_in", 32'(ram_data_in), 32'h0ABCDEF);
      next_cycle();
      bus.wr_req = 1'b0;
      bus.rd_req = 4'b0100;
      set_rd_addr(2, 8'd5);
      #2;
      check("sr_rd_gnt", 32'(bus.rd_gnt), 32'b0100);
      check("sr_ram_read_en", 32'(ram_read_en), 32'd1);
      check("sr_ram_addr_r", 32'(ram_addr_r), 32'd5);
      next_cycle();
      bus.rd_req = '0;
      #2;
      check("sr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("sr_rsp_id", 32'(bus.rsp_id), 32'd2);
      check("sr_rsp_data", 32'(bus.rsp_data), 32'h0ABCDEF);
      check("sr_rsp_err", 32'(bus.rsp_err), 32'd0);
      next_cycle();

      // Burst limiter: W,W,W,R0 repeating.
      bus.wr_req  = 1'b1;
      bus.wr_addr = 8'd20;
      bus.wr_data = 28'h1234567;
      bus.rd_req  = 4'b0001;
      set_rd_addr(0, 8'd5);
      for (int c = 0; c < 8; c++) begin
         #2;
         check("burst_wr_gnt", 32'(bus.wr_gnt), 32'(c % 4 != 3));
         check("burst_rd_gnt", 32'(bus.rd_gnt), 32'(c % 4 == 3));
         check("burst_rsp_valid", 32'(bus.rsp_valid), 32'(c == 4));
         if (c == 4) begin
            check("burst_rsp_id", 32'(bus.rsp_id), 32'd0);
            check("burst_rsp_data", 32'(bus.rsp_data), 32'h0ABCDEF);
         end
         next_cycle();
      end

      // Out-of-range write (addr 200) is granted but dropped.
      bus.rd_req  = '0;
      bus.wr_addr = 8'd200;
      bus.wr_data = 28'h7777777;
      #2;
      check("oor_wr_gnt", 32'(bus.wr_gnt), 32'd1);
      check("oor_ram_write_en", 32'(ram_write_en), 32'd0);
      check("oor_wr_err_before", 32'(bus.wr_err), 32'd0);
      check("burst_tail_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      next_cycle();
      bus.wr_req = 1'b0;
      bus.rd_req = 4'b0010;
      set_rd_addr(1, 8'd63);
      #2;
      check("oor_wr_err", 32'(bus.wr_err), 32'd1);
      check("oor_rd_gnt", 32'(bus.rd_gnt), 32'b0010);
      check("oor_ram_read_en", 32'(ram_read_en), 32'd0);
      next_cycle();
      bus.rd_req = '0;
      #2;
      check("oor_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("oor_rsp_id", 32'(bus.rsp_id), 32'd1);
      check("oor_rsp_err", 32'(bus.rsp_err), 32'd1);
      check("oor_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("oor_wr_err_sticky", 32'(bus.wr_err), 32'd1);
      next_cycle();

      // Read granted, then reset in the next cycle: response suppressed.
      bus.rd_req = 4'b0001;
      set_rd_addr(0, 8'd5);
      #2;
      check("mr_rd_gnt", 32'(bus.rd_gnt), 32'b0001);
      check("mr_ram_read_en", 32'(ram_read_en), 32'd1);
      next_cycle();
      rst        = 1'b1;
      bus.rd_req = '0;
      #2;
      check("mr_rsp_valid_in_rst", 32'(bus.rsp_valid), 32'd0);
      next_cycle();
      rst = 1'b0;
      #2;
      check("mr_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
      check("mr_wr_err_cleared", 32'(bus.wr_err), 32'd0);
      next_cycle();
      bus.rd_req = 4'b1000;
      set_rd_addr(3, 8'd10);
      #2;
      check("mr_new_rd_gnt", 32'(bus.rd_gnt), 32'b1000);
      next_cycle();
      bus.rd_req = '0;
      #2;
      check("mr_new_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("mr_new_rsp_id", 32'(bus.rsp_id), 32'd3);
      check("mr_new_rsp_data", 32'(bus.rsp_data), 32'(d_of(0)));
      next_cycle();
      #2;
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
